// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction-bus request at
// a time and presents the returned word with its PC in a slot for decode.
// Redirects arriving while a request is in flight are deferred until the bus
// answers, so a request is never withdrawn before its response.

package fetch_pkg;
  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;
endpackage

module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        valid_f,
  output fetch_data_t dataF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic [63:0] pend_pc;
  logic [63:0] pend_pc_next;
  logic        load_slot;

  // The bus address is always the current PC; in DRAIN the PC has not yet
  // moved, so the in-flight address stays stable until the response.
  assign ireq_addr = pc;
  assign valid_f   = (state == HOLD);

  // Next-state, next-PC and bus-request decode; redirect outranks everything.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    load_slot    = 1'b0;
    ireq_valid   = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        ireq_valid = 1'b1;
        if (redirect) begin
          if (iresp_data_ok) begin
            // Response completes now, so the new target can be issued at once.
            pc_next = redirect_pc;
          end else begin
            // Request still outstanding: remember the target, wait for the bus.
            pend_pc_next = redirect_pc;
            state_next   = DRAIN;
          end
        end else if (iresp_data_ok) begin
          load_slot  = 1'b1;
          pc_next    = pc + 64'd4;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = REQ;
        end else if (!stall) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        ireq_valid = 1'b1;
        if (redirect) begin
          pend_pc_next = redirect_pc;
        end
        if (iresp_data_ok) begin
          pc_next    = redirect ? redirect_pc : pend_pc;
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC, pending-redirect and fetch-slot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= '0;
      dataF   <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
      if (load_slot) begin
        dataF.raw_instr <= iresp_data;
        dataF.pc        <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: directed walk through the main scenarios, then
// randomized bus/stall/redirect traffic checked against a transaction-level
// reference model of the fetch rules.

module tb_fetch;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        valid_f;
  fetch_data_t dataF;

  int tests = 0;
  int fails = 0;

  // Reference model: is the fetcher running, is a bus request outstanding,
  // must the outstanding response be thrown away, and what is in the slot.
  logic        m_started;
  logic        m_req;
  logic        m_kill;
  logic [63:0] m_tgt;
  logic [63:0] m_pc;
  logic        m_slot_v;
  fetch_data_t m_slot;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .valid_f      (valid_f),
    .dataF        (dataF)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_req     = 1'b0;
    m_kill    = 1'b0;
    m_tgt     = '0;
    m_pc      = RESET_PC;
    m_slot_v  = 1'b0;
    m_slot    = '0;
  endtask

  // One clock of the fetch rules, applied to the inputs seen at that edge.
  task automatic model_edge(input logic ok, input logic [31:0] d, input logic st,
                            input logic rd, input logic [63:0] rpc);
    if (!m_started) begin
      m_started = 1'b1;
      m_req     = 1'b1;
    end else if (m_slot_v) begin
      if (rd) begin
        m_slot_v = 1'b0;
        m_pc     = rpc;
        m_req    = 1'b1;
      end else if (!st) begin
        m_slot_v = 1'b0;
        m_req    = 1'b1;
      end
    end else if (m_req) begin
      if (m_kill) begin
        if (rd) m_tgt = rpc;
        if (ok) begin
          m_pc   = m_tgt;
          m_kill = 1'b0;
        end
      end else if (ok) begin
        if (rd) begin
          m_pc = rpc;
        end else begin
          m_slot.raw_instr = d;
          m_slot.pc        = m_pc;
          m_slot_v         = 1'b1;
          m_req            = 1'b0;
          m_pc             = m_pc + 64'd4;
        end
      end else if (rd) begin
        m_kill = 1'b1;
        m_tgt  = rpc;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ireq_valid"}, {63'd0, ireq_valid}, {63'd0, m_req});
    chk({tag, "_ireq_addr"}, ireq_addr, m_pc);
    chk({tag, "_valid_f"}, {63'd0, valid_f}, {63'd0, m_slot_v});
    if (m_slot_v) begin
      chk({tag, "_slot_pc"}, dataF.pc, m_slot.pc);
      chk({tag, "_slot_instr"}, {32'd0, dataF.raw_instr}, {32'd0, m_slot.raw_instr});
    end
  endtask

  task automatic step(input string tag, input logic ok, input logic [31:0] d, input logic st,
                      input logic rd, input logic [63:0] rpc);
    iresp_data_ok = ok;
    iresp_data    = d;
    stall         = st;
    redirect      = rd;
    redirect_pc   = rpc;
    @(posedge clk);
    model_edge(ok, d, st, rd, rpc);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic        r_ok;
    logic        r_rd;
    logic [63:0] r_pc;

    // Reset state
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_async_addr", ireq_addr, RESET_PC);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid_f", {63'd0, valid_f}, 64'd0);
    chk("rst_dataF_pc", dataF.pc, 64'd0);
    chk("rst_dataF_instr", {32'd0, dataF.raw_instr}, 64'd0);
    reset = 1'b0;

    // Reset and first fetch
    step("t1_idle", 1'b0, '0, 1'b0, 1'b0, '0);
    chk("t1_first_req", {63'd0, ireq_valid}, 64'd1);
    chk("t1_first_addr", ireq_addr, 64'h8000_0000);
    step("t1_resp", 1'b1, 32'h0000_0013, 1'b1, 1'b0, '0);
    chk("t1_valid", {63'd0, valid_f}, 64'd1);
    chk("t1_pc", dataF.pc, 64'h8000_0000);
    chk("t1_instr", {32'd0, dataF.raw_instr}, 64'h13);

    // Stall hold, then resume at +4
    for (int i = 0; i < 3; i++) step("t2_stall", 1'b0, '0, 1'b1, 1'b0, '0);
    chk("t2_slot_kept", {32'd0, dataF.raw_instr}, 64'h13);
    step("t2_release", 1'b0, '0, 1'b0, 1'b0, '0);
    chk("t2_next_addr", ireq_addr, 64'h8000_0004);
    step("t2_resp", 1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);

    // Redirect in HOLD while stalled
    step("t3_redir", 1'b0, '0, 1'b1, 1'b1, 64'h8000_0100);
    chk("t3_valid", {63'd0, valid_f}, 64'd0);
    chk("t3_addr", ireq_addr, 64'h8000_0100);

    // Redirect with request in flight, second redirect while draining
    step("t4_redir_a", 1'b0, '0, 1'b0, 1'b1, 64'h8000_0200);
    chk("t4_old_addr", ireq_addr, 64'h8000_0100);
    step("t4_wait", 1'b0, '0, 1'b0, 1'b0, '0);
    step("t4_redir_b", 1'b0, '0, 1'b0, 1'b1, 64'h8000_0300);
    step("t4_drain_ok", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    chk("t4_no_slot", {63'd0, valid_f}, 64'd0);
    chk("t4_new_addr", ireq_addr, 64'h8000_0300);

    // Simultaneous data_ok and redirect in REQ, then in DRAIN
    step("t5_req_both", 1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 64'h8000_0400);
    chk("t5_addr", ireq_addr, 64'h8000_0400);
    step("t5_to_drain", 1'b0, '0, 1'b0, 1'b1, 64'h8000_0500);
    step("t5_drain_both", 1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 64'h8000_0600);
    chk("t5_drain_addr", ireq_addr, 64'h8000_0600);

    // PC wrap
    step("t6_wrap_redir", 1'b1, '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step("t6_wrap_fetch", 1'b1, 32'h1234_5678, 1'b0, 1'b0, '0);
    chk("t6_wrap_pc", ireq_addr, 64'd0);
    chk("t6_wrap_slot", dataF.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step("t6_wrap_req", 1'b0, '0, 1'b0, 1'b0, '0);

    // Reset mid-REQ
    reset = 1'b1;
    #1;
    chk("t6_rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("t6_rst_addr", ireq_addr, RESET_PC);
    chk("t6_rst_valid_f", {63'd0, valid_f}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_ok = m_req && ($urandom_range(0, 2) == 0);
      r_rd = ($urandom_range(0, 7) == 0);
      r_pc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
      step("rand", r_ok, $urandom, ($urandom_range(0, 1) == 1), r_rd, r_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
